sprite_move_ctrl: RTL and testbench

SPRITE_MOVE_CTRL -- requirements
Module: sprite_move_ctrl

---
 rtl/sprite_move_ctrl.sv | 156 +++++++++++++++
 tb/tb_sprite_move_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_move_ctrl.sv
// rtl/sprite_move_ctrl.sv - keyboard-driven sprite mover with collision-checked probe/verdict handshake
module sprite_move_ctrl #(
    parameter int X_CENTER = 320,
    parameter int Y_CENTER = 240,
    parameter int X_MIN    = 0,
    parameter int X_MAX    = 639,
    parameter int Y_MIN    = 0,
    parameter int Y_MAX    = 479,
    parameter int SIZE     = 30,
    parameter int STEP     = 2,
    parameter int REPEAT   = 4,
    parameter int TIMEOUT  = 15
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic [7:0] keycode,
    output logic       probe_valid,
    input  logic       probe_ready,
    output logic [9:0] probe_x,
    output logic [9:0] probe_y,
    input  logic       verdict_valid,
    input  logic       collision,
    output logic [9:0] spriteX,
    output logic [9:0] spriteY,
    output logic [1:0] dir,
    output logic       blocked,
    output logic       busy
);

    localparam int RW = (REPEAT  < 1) ? 1 : $clog2(REPEAT + 1);
    localparam int TW = $clog2(TIMEOUT + 2);

    localparam logic signed [10:0] C_STEP = 11'(STEP);
    localparam logic signed [10:0] C_X_LO = 11'(X_MIN + SIZE);
    localparam logic signed [10:0] C_X_HI = 11'(X_MAX - SIZE);
    localparam logic signed [10:0] C_Y_LO = 11'(Y_MIN + SIZE);
    localparam logic signed [10:0] C_Y_HI = 11'(Y_MAX - SIZE);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PROBE,
        S_WAIT,
        S_COMMIT
    } state_t;

    state_t          r_state;
    logic [7:0]      r_key;
    logic [RW-1:0]   r_rep;
    logic [TW-1:0]   r_to;

    logic signed [10:0] w_cx;
    logic signed [10:0] w_cy;
    logic signed [10:0] w_nx;
    logic signed [10:0] w_ny;
    logic signed [10:0] w_cand_x;
    logic signed [10:0] w_cand_y;
    logic               w_key_ok;
    logic [1:0]         w_key_dir;
    logic               w_trigger;
    logic               w_stuck;

    assign w_cx = $signed({1'b0, spriteX});
    assign w_cy = $signed({1'b0, spriteY});

    // Decode the key into a direction and an unclamped one-axis step
    always_comb begin
        w_key_ok  = 1'b1;
        w_key_dir = 2'd0;
        w_nx      = w_cx;
        w_ny      = w_cy;
        case (keycode)
            8'h04: begin w_key_dir = 2'd0; w_nx = w_cx - C_STEP; end
            8'h07: begin w_key_dir = 2'd1; w_nx = w_cx + C_STEP; end
            8'h16: begin w_key_dir = 2'd2; w_ny = w_cy + C_STEP; end
            8'h1A: begin w_key_dir = 2'd3; w_ny = w_cy - C_STEP; end
            default: w_key_ok = 1'b0;
        endcase
    end

    // Signed clamp keeps the sprite fully on screen; no wrap at 0 or 1023
    assign w_cand_x = (w_nx < C_X_LO) ? C_X_LO : ((w_nx > C_X_HI) ? C_X_HI : w_nx);
    assign w_cand_y = (w_ny < C_Y_LO) ? C_Y_LO : ((w_ny > C_Y_HI) ? C_Y_HI : w_ny);

    assign w_trigger = w_key_ok && ((keycode != r_key) || (r_rep == '0));
    assign w_stuck   = (w_cand_x[9:0] == spriteX) && (w_cand_y[9:0] == spriteY);

    // Move FSM: trigger, offer candidate, await verdict, commit position
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            r_state     <= S_IDLE;
            r_key       <= 8'h00;
            r_rep       <= '0;
            r_to        <= '0;
            spriteX     <= 10'(X_CENTER);
            spriteY     <= 10'(Y_CENTER);
            probe_x     <= 10'd0;
            probe_y     <= 10'd0;
            probe_valid <= 1'b0;
            dir         <= 2'd0;
            blocked     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            blocked <= 1'b0;
            if (r_rep != '0) begin
                r_rep <= r_rep - RW'(1);
            end
            case (r_state)
                S_IDLE: begin
                    if (!w_key_ok) begin
                        // Releasing the key lets the same key retrigger at once
                        r_key <= 8'h00;
                    end else if (w_trigger) begin
                        r_key <= keycode;
                        dir   <= w_key_dir;
                        r_rep <= RW'(REPEAT - 1);
                        if (w_stuck) begin
                            blocked <= 1'b1;
                        end else begin
                            probe_x     <= w_cand_x[9:0];
                            probe_y     <= w_cand_y[9:0];
                            probe_valid <= 1'b1;
                            busy        <= 1'b1;
                            r_state     <= S_PROBE;
                        end
                    end
                end
                S_PROBE: begin
                    if (probe_ready) begin
                        probe_valid <= 1'b0;
                        r_to        <= '0;
                        r_state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (verdict_valid && !collision) begin
                        r_state <= S_COMMIT;
                    end else if (verdict_valid || (r_to == TW'(TIMEOUT))) begin
                        blocked <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_to <= r_to + TW'(1);
                    end
                end
                S_COMMIT: begin
                    spriteX <= probe_x;
                    spriteY <= probe_y;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_move_ctrl.sv
// tb/tb_sprite_move_ctrl.sv - directed self-checking bench for sprite_move_ctrl
module tb_sprite_move_ctrl;

    logic       frame_clk = 1'b0;
    logic       Reset = 1'b1;
    logic [7:0] keycode = 8'h00;
    logic       probe_valid;
    logic       probe_ready = 1'b0;
    logic [9:0] probe_x;
    logic [9:0] probe_y;
    logic       verdict_valid = 1'b0;
    logic       collision = 1'b0;
    logic [9:0] spriteX;
    logic [9:0] spriteY;
    logic [1:0] dir;
    logic       blocked;
    logic       busy;

    logic tb_auto = 1'b0;
    logic tb_coll = 1'b0;
    logic tb_man_ready = 1'b0;
    logic tb_man_verdict = 1'b0;
    logic r_pend = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    sprite_move_ctrl dut (
        .frame_clk    (frame_clk),
        .Reset        (Reset),
        .keycode      (keycode),
        .probe_valid  (probe_valid),
        .probe_ready  (probe_ready),
        .probe_x      (probe_x),
        .probe_y      (probe_y),
        .verdict_valid(verdict_valid),
        .collision    (collision),
        .spriteX      (spriteX),
        .spriteY      (spriteY),
        .dir          (dir),
        .blocked      (blocked),
        .busy         (busy)
    );

    always #5 frame_clk = ~frame_clk;

    // Collision checker model: auto mode grants at once and answers one cycle later
    always @(negedge frame_clk) begin
        if (tb_auto) begin
            probe_ready   = 1'b1;
            verdict_valid = r_pend;
            collision     = tb_coll;
            r_pend        = probe_valid;
        end else begin
            probe_ready   = tb_man_ready;
            verdict_valid = tb_man_verdict;
            collision     = tb_coll;
            r_pend        = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge frame_clk);
        #1;
    endtask

    int changes;
    int first_chg;
    int second_chg;
    int waited;
    logic [9:0] prev_y;

    initial begin
        // Reset values
        tick();
        tick();
        chk("rst_x", 32'(spriteX), 320);
        chk("rst_y", 32'(spriteY), 240);
        chk("rst_flags", {27'd0, dir, blocked, probe_valid, busy}, 0);
        chk("rst_probe", {12'd0, probe_x, probe_y}, 0);
        Reset = 1'b0;
        tick();

        // Scenario 1: single right move, 4-cycle round trip
        tb_auto = 1'b1; tb_coll = 1'b0;
        keycode = 8'h07;
        tick();
        keycode = 8'h00;
        chk("s1_probe_valid", 32'(probe_valid), 1);
        chk("s1_probe_xy", {12'd0, probe_x, probe_y}, {12'd0, 10'd322, 10'd240});
        chk("s1_busy", 32'(busy), 1);
        chk("s1_dir", 32'(dir), 1);
        tick();
        tick();
        chk("s1_x_before_commit", 32'(spriteX), 320);
        tick();
        chk("s1_x_commit", 32'(spriteX), 322);
        chk("s1_idle", 32'(busy), 0);
        tick();

        // Scenario 2: hold up for 40 cycles
        keycode = 8'h1A;
        changes = 0; first_chg = -1; second_chg = -1;
        prev_y = spriteY;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (spriteY != prev_y) begin
                if (changes == 0) first_chg = i;
                if (changes == 1) second_chg = i;
                changes++;
            end
            prev_y = spriteY;
        end
        keycode = 8'h00;
        chk("s2_moves", 32'(changes), 10);
        chk("s2_spacing", 32'(second_chg - first_chg), 4);
        chk("s2_y", 32'(spriteY), 220);
        chk("s2_dir", 32'(dir), 3);
        tick();
        tick();

        // Scenario 4a: left move rejected by collision verdict
        tb_coll = 1'b1;
        keycode = 8'h04;
        tick();
        keycode = 8'h00;
        chk("s4a_probe_x", 32'(probe_x), 320);
        tick();
        tick();
        chk("s4a_blocked", 32'(blocked), 1);
        chk("s4a_busy", 32'(busy), 0);
        tick();
        chk("s4a_pulse_end", 32'(blocked), 0);
        chk("s4a_x", 32'(spriteX), 322);
        tb_coll = 1'b0;
        tb_auto = 1'b0;
        tb_man_ready = 1'b1;
        tb_man_verdict = 1'b0;
        tick();
        tick();

        // Scenario 4b: no verdict, timeout rejects the move
        keycode = 8'h04;
        tick();
        keycode = 8'h00;
        waited = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            waited = i;
            if (blocked) break;
        end
        chk("s4b_timeout_edge", 32'(waited), 17);
        chk("s4b_blocked", 32'(blocked), 1);
        chk("s4b_x", 32'(spriteX), 322);
        tb_man_ready = 1'b0;
        tick();
        tick();

        // Scenario 5: stalled handshake while the keycode wanders
        keycode = 8'h04;
        tick();
        chk("s5_probe_start", {11'd0, probe_valid, probe_x, probe_y}, {11'd0, 1'b1, 10'd320, 10'd220});
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: keycode = 8'h07;
                1: keycode = 8'h16;
                2: keycode = 8'h1A;
                3: keycode = 8'h00;
                default: keycode = 8'h07;
            endcase
            tick();
            chk("s5_probe_stable", {11'd0, probe_valid, probe_x, probe_y}, {11'd0, 1'b1, 10'd320, 10'd220});
        end
        keycode = 8'h00;
        tb_man_ready = 1'b1;
        tick();
        chk("s5_probe_taken", 32'(probe_valid), 0);
        tb_man_ready = 1'b0;
        tb_man_verdict = 1'b1;
        tick();
        tb_man_verdict = 1'b0;
        chk("s5_x_latency", 32'(spriteX), 322);
        tick();
        chk("s5_x_commit", 32'(spriteX), 320);
        chk("s5_dir", 32'(dir), 0);
        tick();

        // Scenario 6: reset asserted during WAIT
        tb_man_ready = 1'b1;
        keycode = 8'h07;
        tick();
        keycode = 8'h00;
        tick();
        chk("s6_in_wait", {30'd0, busy, probe_valid}, 2);
        Reset = 1'b1;
        #1;
        chk("s6_async_xy", {12'd0, spriteX, spriteY}, {12'd0, 10'd320, 10'd240});
        chk("s6_async_flags", {27'd0, dir, blocked, probe_valid, busy}, 0);
        chk("s6_async_probe", {12'd0, probe_x, probe_y}, 0);
        tick();
        Reset = 1'b0;
        tb_man_ready = 1'b0;
        tb_man_verdict = 1'b1;
        tick();
        tick();
        tick();
        tb_man_verdict = 1'b0;
        chk("s6_ignored_x", 32'(spriteX), 320);
        chk("s6_ignored_busy", 32'(busy), 0);
        tick();

        // Scenario 3: drive to the right edge, then a further right press is blocked
        tb_auto = 1'b1;
        keycode = 8'h07;
        for (int i = 0; i < 600; i++) tick();
        keycode = 8'h00;
        tick();
        tick();
        chk("s3_edge_x", 32'(spriteX), 609);
        chk("s3_edge_y", 32'(spriteY), 240);
        keycode = 8'h07;
        tick();
        keycode = 8'h00;
        chk("s3_blocked", 32'(blocked), 1);
        chk("s3_no_probe", {30'd0, probe_valid, busy}, 0);
        tick();
        chk("s3_pulse_end", 32'(blocked), 0);
        chk("s3_x_kept", 32'(spriteX), 609);
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
